irq_ctrl: RTL

Memory-mapped interrupt controller between the hardware interrupt sources (timer1 IRQ, timer2 IRQ, external `interrupt` pin and spare lines) and the CPU datapath. Latches edge- or level-sensitive requests, applies a software mask, selects one source by fixed priority, and sequences a request / acknowledge / end-of-interrupt handshake with the CPU. It attaches to the system bridge as a peripheral with its own write enable and read data, like the timers.

---
 rtl/irq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - Memory-mapped interrupt controller: edge/level latching, masking,
// fixed-priority selection and request/ack/EOI handshake with the CPU.
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      Addr,
    input  logic            WE,
    input  logic [31:0]     Din,
    output logic [31:0]     Dout,
    input  logic [NSRC-1:0] src,
    input  logic            ack,
    output logic            irq,
    output logic [2:0]      irq_id,
    output logic [NSRC-1:0] hwint
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state;
    logic [NSRC-1:0] pend, mask, mode, src_q;
    logic [NSRC-1:0] pend_nxt, mask_nxt, mode_nxt;
    logic [NSRC-1:0] w1c, ack_clr;
    logic [7:0]      pend_nxt8, mask_nxt8;
    logic [2:0]      cand;
    logic            cand_vld;
    logic            wr_pend, wr_mask, wr_mode, eoi, take, still_req;
    logic            unused_din;

    assign wr_pend    = WE && (Addr == 2'd0);
    assign wr_mask    = WE && (Addr == 2'd1);
    assign wr_mode    = WE && (Addr == 2'd2);
    assign eoi        = WE && (Addr == 2'd3) && (state == SERVICE);
    assign take       = (state == REQ) && ack;
    assign unused_din = ^Din[31:NSRC];

    assign w1c      = wr_pend ? Din[NSRC-1:0] : '0;
    assign mask_nxt = wr_mask ? Din[NSRC-1:0] : mask;
    assign mode_nxt = wr_mode ? Din[NSRC-1:0] : mode;
    assign hwint    = pend & mask;

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (take && (irq_id == 3'(i))) ack_clr[i] = 1'b1;
        end
    end

    // A new edge beats a same-cycle software or acknowledge clear.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < NSRC; i++) begin
            if (mode[i])
                pend_nxt[i] = (src[i] & ~src_q[i]) | (pend[i] & ~(w1c[i] | ack_clr[i]));
            else
                pend_nxt[i] = src[i];
        end
    end

    always_comb begin
        pend_nxt8 = '0;
        mask_nxt8 = '0;
        pend_nxt8[NSRC-1:0] = pend_nxt;
        mask_nxt8[NSRC-1:0] = mask_nxt;
    end

    // Withdrawal looks at next-cycle pend/mask so a dropped level source
    // releases irq on the same edge its pend bit falls.
    assign still_req = pend_nxt8[irq_id] & mask_nxt8[irq_id];

    always_comb begin
        cand     = '0;
        cand_vld = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i] & mask[i]) begin
                cand     = 3'(i);
                cand_vld = 1'b1;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            2'd0: Dout[NSRC-1:0] = pend;
            2'd1: Dout[NSRC-1:0] = mask;
            2'd2: Dout[NSRC-1:0] = mode;
            default: begin
                Dout[31]  = (state == SERVICE);
                Dout[2:0] = irq_id;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            irq    <= 1'b0;
            irq_id <= '0;
            pend   <= '0;
            mask   <= '0;
            mode   <= '0;
            src_q  <= '0;
        end else begin
            src_q <= src;
            pend  <= pend_nxt;
            mask  <= mask_nxt;
            mode  <= mode_nxt;
            case (state)
                IDLE: begin
                    if (cand_vld) begin
                        irq_id <= cand;
                        irq    <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    if (ack) begin
                        irq   <= 1'b0;
                        state <= SERVICE;
                    end else if (!still_req) begin
                        irq   <= 1'b0;
                        state <= IDLE;
                    end
                end
                SERVICE: begin
                    irq <= 1'b0;
                    if (eoi) state <= IDLE;
                end
                default: begin
                    irq   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
